// File: rtl/urand_pair_src_if.sv
`default_nettype none
// ============================================================================
// Module      : urand_pair_src_if
// Description : Control and stream bundle for the uniform-pair source.
//               master : the source itself (drives the stream and status).
//               slave  : the controller/consumer side.
//   seed_load/seed : load both engines from seed (honoured in IDLE)
//   start/count    : begin a run of count pairs (honoured in IDLE)
//   pushout/U1/U2  : push-only stream of uniform doubles in (0,1]
//   busy/done      : run in progress / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface urand_pair_src_if;
    logic        seed_load;
    logic [63:0] seed;
    logic        start;
    logic [15:0] count;
    logic        pushout;
    logic [63:0] U1;
    logic [63:0] U2;
    logic        busy;
    logic        done;

    modport master (
        input  seed_load, seed, start, count,
        output pushout, U1, U2, busy, done
    );

    modport slave (
        output seed_load, seed, start, count,
        input  pushout, U1, U2, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/urand_pair_src.sv
`default_nettype none
// ============================================================================
// Module      : urand_pair_src
// Description : Two xorshift64 engines feeding a two-stage integer-to-double
//               pipeline. Issues a programmed number of (U1,U2) pairs, one
//               every GAP+1 cycles, then pulses done.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : urand_pair_src_if.master (control inputs, stream/status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module urand_pair_src #(
    parameter int unsigned GAP = 0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    urand_pair_src_if.master    bus
);

    localparam logic [63:0] C_SEED_A = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] C_SEED_B = 64'hD1B54A32D192ED03;
    localparam logic [7:0]  C_GAP    = 8'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [15:0]  r_count;
    logic [15:0]  r_issued;
    logic [7:0]   r_gap;
    logic [63:0]  r_eng_a;
    logic [63:0]  r_eng_b;
    logic         r_s1_valid;
    logic [52:0]  r_s1_va;
    logic [52:0]  r_s1_vb;
    logic         r_pushout;
    logic [63:0]  r_u1;
    logic [63:0]  r_u2;

    logic         w_issue;
    logic         w_last;
    logic         w_idle_start;
    logic         w_idle_load;
    logic [63:0]  w_load_a;
    logic [63:0]  w_load_b;

    function automatic logic [63:0] f_xorshift(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    // v is in 1..2^52, so the double is exact: exponent from the MSB
    // position, mantissa is everything below the MSB left-justified.
    function automatic logic [63:0] f_to_double(input logic [52:0] v);
        logic [5:0]  p;
        logic [52:0] sh;
        p = 6'd0;
        for (int i = 0; i < 53; i++) begin
            if (v[i]) p = 6'(i);
        end
        sh = v << (6'd52 - p);
        return {1'b0, 11'd971 + 11'(p), sh[51:0]};
    endfunction

    assign w_idle_start = (r_state == S_IDLE) && bus.start;
    assign w_idle_load  = (r_state == S_IDLE) && bus.seed_load;
    assign w_issue      = (r_state == S_RUN) && (r_gap == 8'd0);
    assign w_last       = w_issue && (({1'b0, r_issued} + 17'd1) == {1'b0, r_count});

    // A zero state would lock an xorshift engine at zero forever.
    assign w_load_a = (bus.seed == 64'd0) ? C_SEED_A : bus.seed;
    assign w_load_b = ((bus.seed ^ C_SEED_B) == 64'd0) ? C_SEED_B : (bus.seed ^ C_SEED_B);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = (bus.count != 16'd0) ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            // Stage 1 empty means the last pair is already in stage 2.
            S_DRAIN: if (!r_s1_valid) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= 16'd0;
            r_issued <= 16'd0;
            r_gap    <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_idle_start && (bus.count != 16'd0)) begin
                r_count  <= bus.count;
                r_issued <= 16'd0;
                r_gap    <= 8'd0;
            end else if (w_issue) begin
                r_issued <= r_issued + 16'd1;
                r_gap    <= C_GAP;
            end else if (r_state == S_RUN) begin
                r_gap <= r_gap - 8'd1;
            end
        end
    end

    // Engines and stage 1: the issued sample is the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eng_a    <= C_SEED_A;
            r_eng_b    <= C_SEED_B;
            r_s1_valid <= 1'b0;
            r_s1_va    <= 53'd0;
            r_s1_vb    <= 53'd0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_idle_load) begin
                r_eng_a <= w_load_a;
                r_eng_b <= w_load_b;
            end else if (w_issue) begin
                r_eng_a <= f_xorshift(r_eng_a);
                r_eng_b <= f_xorshift(r_eng_b);
            end
            if (w_issue) begin
                r_s1_va <= {1'b0, r_eng_a[63:12]} + 53'd1;
                r_s1_vb <= {1'b0, r_eng_b[63:12]} + 53'd1;
            end
        end
    end

    // Stage 2: normalise; outputs hold while no new pair arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pushout <= 1'b0;
            r_u1      <= 64'd0;
            r_u2      <= 64'd0;
        end else begin
            r_pushout <= r_s1_valid;
            if (r_s1_valid) begin
                r_u1 <= f_to_double(r_s1_va);
                r_u2 <= f_to_double(r_s1_vb);
            end
        end
    end

    assign bus.pushout = r_pushout;
    assign bus.U1      = r_u1;
    assign bus.U2      = r_u2;
    assign bus.busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done    = (r_state == S_DONE);

endmodule
`default_nettype wire
